// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        SW_HOLD   = 2'd3
    } rst_seq_state_e;

    // Wide enough for the largest count plus one spare bit so nothing wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_sequencer_sync.sv
// Active-low reset synchronizer: asserts asynchronously, releases after STAGES clk edges.
module rst_sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic sync_rst_n
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) sync_q <= '0;
        else         sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end

    assign sync_rst_n = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset tree sequencer: filters PLL lock, then releases reset domains in index order.
//
// state     | meaning
// WAIT_LOCK | all domains held; counting consecutive lock-high samples
// RELEASE   | releasing one domain every DELAY cycles, lowest index first
// RUN       | all domains released, done_o high
// SW_HOLD   | software reset: all domains held for DELAY cycles
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int STAGES      = 2,
    parameter int LOCK_CYCLES = 16,
    parameter int DELAY       = 32
) (
    input  logic                   clk,
    input  logic                   async_rst_n_i,
    input  logic                   lock_i,
    input  logic                   sw_rst_req_i,
    output logic [NUM_DOMAINS-1:0] rst_n_o,
    output logic                   done_o,
    output logic                   sw_rst_ack_o
);

    localparam int CW = cnt_width(LOCK_CYCLES, DELAY, NUM_DOMAINS);

    logic                 rst_sync_n;
    logic                 lock_s;
    rst_seq_state_e       state;
    logic [CW-1:0]        lock_cnt;
    logic [CW-1:0]        dly_cnt;
    logic [CW-1:0]        k;
    logic                 sw_pending;

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] lock_q;

    rst_sync_n #(.STAGES(STAGES)) u_rst_sync (
        .clk        (clk),
        .arst_n     (async_rst_n_i),
        .sync_rst_n (rst_sync_n)
    );

    // Reset from the pin, not rst_sync_n, so a steady lock is already visible at release.
    always_ff @(posedge clk or negedge async_rst_n_i) begin
        if (!async_rst_n_i) lock_q <= '0;
        else                lock_q <= {lock_q[STAGES-2:0], lock_i};
    end

    assign lock_s = lock_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state        <= WAIT_LOCK;
            lock_cnt     <= '0;
            dly_cnt      <= '0;
            k            <= '0;
            sw_pending   <= 1'b0;
            rst_n_o      <= '0;
            done_o       <= 1'b0;
            sw_rst_ack_o <= 1'b0;
        end else begin
            sw_rst_ack_o <= 1'b0;
            if (state != WAIT_LOCK && !lock_s) begin
                state      <= WAIT_LOCK;
                lock_cnt   <= '0;
                dly_cnt    <= '0;
                k          <= '0;
                sw_pending <= 1'b0;
                rst_n_o    <= '0;
                done_o     <= 1'b0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        if (!lock_s) begin
                            lock_cnt <= '0;
                        end else if (lock_cnt == CW'(LOCK_CYCLES - 1)) begin
                            state    <= RELEASE;
                            lock_cnt <= '0;
                            dly_cnt  <= '0;
                            k        <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (dly_cnt == CW'(DELAY - 1)) begin
                            dly_cnt <= '0;
                            for (int i = 0; i < NUM_DOMAINS; i++) begin
                                if (k == CW'(i)) rst_n_o[i] <= 1'b1;
                            end
                            if (k == CW'(NUM_DOMAINS - 1)) begin
                                state  <= RUN;
                                done_o <= 1'b1;
                                k      <= '0;
                            end else begin
                                k <= k + 1'b1;
                            end
                        end else begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (sw_pending) begin
                            sw_rst_ack_o <= 1'b1;
                            sw_pending   <= 1'b0;
                        end
                        if (sw_rst_req_i) begin
                            state      <= SW_HOLD;
                            dly_cnt    <= '0;
                            sw_pending <= 1'b1;
                            rst_n_o    <= '0;
                            done_o     <= 1'b0;
                        end
                    end
                    SW_HOLD: begin
                        if (dly_cnt == CW'(DELAY - 1)) begin
                            state   <= RELEASE;
                            dly_cnt <= '0;
                            k       <= '0;
                        end else begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                    default: state <= WAIT_LOCK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output-change events vs observed ones.
module tb_rst_sequencer;

    typedef struct packed {
        int         cyc;
        logic [2:0] rst;
        logic       done;
        logic       ack;
    } ev_t;

    logic       clk = 1'b0;
    logic       async_rst_n_i = 1'b1;
    logic       lock_i = 1'b1;
    logic       sw_rst_req_i = 1'b0;
    logic [2:0] rst_n_o;
    logic       done_o;
    logic       sw_rst_ack_o;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t e, o;

    logic [2:0] prev_rst  = 3'b000;
    logic       prev_done = 1'b0;
    logic       prev_ack  = 1'b0;

    rst_sequencer #(
        .NUM_DOMAINS (3),
        .STAGES      (2),
        .LOCK_CYCLES (4),
        .DELAY       (8)
    ) dut (
        .clk           (clk),
        .async_rst_n_i (async_rst_n_i),
        .lock_i        (lock_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .rst_n_o       (rst_n_o),
        .done_o        (done_o),
        .sw_rst_ack_o  (sw_rst_ack_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every change of the outputs, stamped with the edge that caused it.
    always @(negedge clk) begin
        if ({rst_n_o, done_o, sw_rst_ack_o} !== {prev_rst, prev_done, prev_ack}) begin
            obs_q.push_back(ev_t'{cyc, rst_n_o, done_o, sw_rst_ack_o});
            prev_rst  = rst_n_o;
            prev_done = done_o;
            prev_ack  = sw_rst_ack_o;
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_seq(input int r0);
        exp_q.push_back(ev_t'{r0,      3'b001, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{r0 + 8,  3'b011, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{r0 + 16, 3'b111, 1'b1, 1'b0});
    endtask

    task automatic start_from_reset(output int c);
        async_rst_n_i = 1'b0;
        lock_i        = 1'b1;
        wait_cyc(cyc + 2);
        obs_q.delete();
        exp_q.delete();
        c = cyc;
        async_rst_n_i = 1'b1;
    endtask

    task automatic test_reset;
        #1 async_rst_n_i = 1'b0;
        wait_cyc(3);
        checks++;
        if (rst_n_o !== 3'b000) begin
            failures++;
            $display("FAIL reset_rst_n: got %b want 000", rst_n_o);
        end
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b want 0", done_o);
        end
        checks++;
        if (sw_rst_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack: got %b want 0", sw_rst_ack_o);
        end
    endtask

    task automatic test_powerup;
        int c;
        obs_q.delete();
        exp_q.delete();
        c = cyc;
        async_rst_n_i = 1'b1;
        push_seq(c + 14);
        wait_cyc(c + 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL powerup: got no event, want cyc=%0d rst=%b done=%b ack=%b", e.cyc - c, e.rst, e.done, e.ack);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL powerup: got cyc=%0d rst=%b done=%b ack=%b, want cyc=%0d rst=%b done=%b ack=%b",
                             o.cyc - c, o.rst, o.done, o.ack, e.cyc - c, e.rst, e.done, e.ack);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL powerup_extra: got %0d unexpected events, want 0", obs_q.size());
        end
    endtask

    task automatic test_sw_reset;
        int s;
        obs_q.delete();
        exp_q.delete();
        s = cyc;
        sw_rst_req_i = 1'b1;
        wait_cyc(s + 1);
        sw_rst_req_i = 1'b0;
        exp_q.push_back(ev_t'{s + 1, 3'b000, 1'b0, 1'b0});
        push_seq(s + 17);
        exp_q.push_back(ev_t'{s + 34, 3'b111, 1'b1, 1'b1});
        exp_q.push_back(ev_t'{s + 35, 3'b111, 1'b1, 1'b0});
        wait_cyc(s + 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL sw_reset: got no event, want cyc=%0d rst=%b done=%b ack=%b", e.cyc - s, e.rst, e.done, e.ack);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL sw_reset: got cyc=%0d rst=%b done=%b ack=%b, want cyc=%0d rst=%b done=%b ack=%b",
                             o.cyc - s, o.rst, o.done, o.ack, e.cyc - s, e.rst, e.done, e.ack);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL sw_reset_extra: got %0d unexpected events, want 0", obs_q.size());
        end
    endtask

    task automatic test_lock_drop;
        int d;
        obs_q.delete();
        exp_q.delete();
        d = cyc;
        lock_i = 1'b0;
        exp_q.push_back(ev_t'{d + 3, 3'b000, 1'b0, 1'b0});
        wait_cyc(d + 5);
        lock_i = 1'b1;
        push_seq(d + 19);
        wait_cyc(d + 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL lock_drop: got no event, want cyc=%0d rst=%b done=%b ack=%b", e.cyc - d, e.rst, e.done, e.ack);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL lock_drop: got cyc=%0d rst=%b done=%b ack=%b, want cyc=%0d rst=%b done=%b ack=%b",
                             o.cyc - d, o.rst, o.done, o.ack, e.cyc - d, e.rst, e.done, e.ack);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL lock_drop_extra: got %0d unexpected events, want 0", obs_q.size());
        end
    endtask

    task automatic test_lock_glitch;
        int c;
        start_from_reset(c);
        wait_cyc(c + 3);
        lock_i = 1'b0;
        wait_cyc(c + 4);
        lock_i = 1'b1;
        push_seq(c + 18);
        wait_cyc(c + 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL lock_glitch: got no event, want cyc=%0d rst=%b done=%b ack=%b", e.cyc - c, e.rst, e.done, e.ack);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL lock_glitch: got cyc=%0d rst=%b done=%b ack=%b, want cyc=%0d rst=%b done=%b ack=%b",
                             o.cyc - c, o.rst, o.done, o.ack, e.cyc - c, e.rst, e.done, e.ack);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL lock_glitch_extra: got %0d unexpected events, want 0", obs_q.size());
        end
    endtask

    task automatic test_sw_ignored;
        int c, d;
        start_from_reset(c);
        push_seq(c + 14);
        wait_cyc(c + 16);
        sw_rst_req_i = 1'b1;
        wait_cyc(c + 17);
        sw_rst_req_i = 1'b0;
        wait_cyc(c + 42);
        d = cyc;
        lock_i = 1'b0;
        exp_q.push_back(ev_t'{d + 3, 3'b000, 1'b0, 1'b0});
        wait_cyc(d + 2);
        sw_rst_req_i = 1'b1;
        wait_cyc(d + 3);
        sw_rst_req_i = 1'b0;
        wait_cyc(d + 5);
        lock_i = 1'b1;
        push_seq(d + 19);
        wait_cyc(d + 45);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL sw_ignored: got no event, want cyc=%0d rst=%b done=%b ack=%b", e.cyc - c, e.rst, e.done, e.ack);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL sw_ignored: got cyc=%0d rst=%b done=%b ack=%b, want cyc=%0d rst=%b done=%b ack=%b",
                             o.cyc - c, o.rst, o.done, o.ack, e.cyc - c, e.rst, e.done, e.ack);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL sw_ignored_extra: got %0d unexpected events, want 0", obs_q.size());
        end
    endtask

    task automatic test_async_mid_release;
        int c, f;
        start_from_reset(c);
        exp_q.push_back(ev_t'{c + 14, 3'b001, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{c + 17, 3'b000, 1'b0, 1'b0});
        wait_cyc(c + 16);
        #1 async_rst_n_i = 1'b0;
        #1;
        checks++;
        if (rst_n_o !== 3'b000) begin
            failures++;
            $display("FAIL async_immediate_rst_n: got %b want 000", rst_n_o);
        end
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL async_immediate_done: got %b want 0", done_o);
        end
        wait_cyc(c + 18);
        f = cyc;
        async_rst_n_i = 1'b1;
        push_seq(f + 14);
        wait_cyc(f + 36);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL async_mid_release: got no event, want cyc=%0d rst=%b done=%b ack=%b", e.cyc - c, e.rst, e.done, e.ack);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL async_mid_release: got cyc=%0d rst=%b done=%b ack=%b, want cyc=%0d rst=%b done=%b ack=%b",
                             o.cyc - c, o.rst, o.done, o.ack, e.cyc - c, e.rst, e.done, e.ack);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL async_mid_release_extra: got %0d unexpected events, want 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_sw_reset();
        test_lock_drop();
        test_lock_glitch();
        test_sw_ignored();
        test_async_mid_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
